// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised LFSR stream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_pkg;

  // Stream controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } lfsr_state_t;

  // Maximal-length Fibonacci tap masks. Bit i set means state[i] feeds the XOR.
  // Each mask includes bit N-1, so a non-zero state can never reach zero.
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;                  // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;               // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;          // x^32+x^22+x^2+x+1
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  // Reset value and replacement for an all-zero seed.
  localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function: STEP Fibonacci shifts folded into one cycle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module lfsr_next #(
  parameter int              N    = 32,
  parameter logic [N-1:0]    TAPS = N'(32'h8020_0003),
  parameter int              STEP = 1
) (
  input  logic [N-1:0] state_i,
  output logic [N-1:0] next_o
);

  logic [N-1:0] s;

  // Unrolled shift chain: feedback is the parity of the tapped bits, MSB drops out.
  always_comb begin
    s = state_i;
    for (int i = 0; i < STEP; i++) begin
      s = {s[N-2:0], ^(s & TAPS)};
    end
    next_o = s;
  end

endmodule

// File: rtl/lfsr_stream.sv
// LFSR word generator presented as a valid/ready stream with RUN, BURST and single-step GO.
// Latency: Q is the state register; first word is the current state, visible the cycle after entering RUN/BURST.
// Backpressure: Q is held while Q_VALID & !Q_READY; the state advances only on a transfer.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int           N            = 32,
  parameter logic [N-1:0] TAPS         = N'(LFSR_TAPS_32),
  parameter int           STEP         = 1,
  parameter int           CNT_W        = 16,
  parameter logic [N-1:0] DEFAULT_SEED = N'(LFSR_DEFAULT_SEED)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INIT,
  input  logic [N-1:0]     SEED,
  input  logic             GO,
  input  logic             RUN,
  input  logic             BURST_START,
  input  logic [CNT_W-1:0] BURST_LEN,
  output logic [N-1:0]     Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO_ERR
);

  lfsr_state_t      state_q, state_d;
  logic [N-1:0]     lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q;
  logic             done_q, done_d;
  logic             zerr_q, zerr_d;
  logic [N-1:0]     lfsr_adv;
  logic             xfer;

  lfsr_next #(
    .N    (N),
    .TAPS (TAPS),
    .STEP (STEP)
  ) u_next (
    .state_i (lfsr_q),
    .next_o  (lfsr_adv)
  );

  assign xfer = vld_q & Q_READY;

  // Next-state and control: INIT overrides everything, then per-state handling.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    zerr_d  = 1'b0;

    if (INIT) begin
      // A reload abandons any pending word and never signals DONE.
      state_d = ST_IDLE;
      if (SEED == '0) begin
        lfsr_d = DEFAULT_SEED;
        zerr_d = 1'b1;
      end else begin
        lfsr_d = SEED;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (BURST_START) begin
            if (BURST_LEN != '0) begin
              cnt_d   = BURST_LEN;
              state_d = ST_BURST;
            end else begin
              done_d = 1'b1;
            end
          end else if (RUN) begin
            state_d = ST_RUN;
          end else if (GO) begin
            lfsr_d = lfsr_adv;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            lfsr_d = lfsr_adv;
          end
          // Leave only once no word is left stalled: Q_READY high means this word goes now.
          if (!RUN && Q_READY) begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (xfer) begin
            lfsr_d = lfsr_adv;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, data and pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      lfsr_q  <= DEFAULT_SEED;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      vld_q   <= (state_d != ST_IDLE);
      done_q  <= done_d;
      zerr_q  <= zerr_d;
    end
  end

  assign Q        = lfsr_q;
  assign Q_VALID  = vld_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign ZERO_ERR = zerr_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: stepping, zero seed, burst/run backpressure, abort and reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: Q_READY driven directly by the stimulus.
`timescale 1ns/1ps
module tb_lfsr_stream;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        INIT;
  logic [31:0] SEED;
  logic        GO;
  logic        go2;
  logic        RUN;
  logic        BURST_START;
  logic [15:0] BURST_LEN;
  logic        Q_READY;
  logic [31:0] Q, q2;
  logic        Q_VALID, BUSY, DONE, ZERO_ERR;
  logic        vld2, busy2, done2, zerr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  lfsr_stream u_dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INIT        (INIT),
    .SEED        (SEED),
    .GO          (GO),
    .RUN         (RUN),
    .BURST_START (BURST_START),
    .BURST_LEN   (BURST_LEN),
    .Q           (Q),
    .Q_VALID     (Q_VALID),
    .Q_READY     (Q_READY),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ZERO_ERR    (ZERO_ERR)
  );

  // Two-shifts-per-advance build, driven only by its own GO.
  lfsr_stream #(.STEP(2)) u_dut2 (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INIT        (INIT),
    .SEED        (SEED),
    .GO          (go2),
    .RUN         (1'b0),
    .BURST_START (1'b0),
    .BURST_LEN   (16'd0),
    .Q           (q2),
    .Q_VALID     (vld2),
    .Q_READY     (1'b1),
    .BUSY        (busy2),
    .DONE        (done2),
    .ZERO_ERR    (zerr2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    INIT = 1'b1;
    SEED = s;
    tick();
    INIT = 1'b0;
  endtask

  initial begin
    int done_cnt;
    RST_N = 1'b1; INIT = 1'b0; SEED = '0; GO = 1'b0; go2 = 1'b0;
    RUN = 1'b0; BURST_START = 1'b0; BURST_LEN = '0; Q_READY = 1'b0;

    // Asynchronous reset from a non-default state.
    tick();
    load_seed(32'h0000_0055);
    chk("init_55", Q, 32'h55);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_q", Q, 32'h1);
    chk("rst_vld", Q_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_zerr", ZERO_ERR, 1'b0);
    #3 RST_N = 1'b1;
    tick();

    // Seed and single-step; STEP=2 build advances twice per GO.
    load_seed(32'h0000_0001);
    chk("seed1", Q, 32'h1);
    chk("seed1_zerr", ZERO_ERR, 1'b0);
    GO = 1'b1; go2 = 1'b1;
    tick();
    go2 = 1'b0;
    chk("go1", Q, 32'h3);
    chk("step2_go", q2, 32'h6);
    tick(); chk("go2", Q, 32'h6);
    tick(); chk("go3", Q, 32'hD);
    GO = 1'b0;
    chk("go_idle_busy", BUSY, 1'b0);
    chk("go_idle_vld", Q_VALID, 1'b0);

    // MSB wraps out.
    load_seed(32'h8000_0000);
    GO = 1'b1; tick(); GO = 1'b0;
    chk("wrap", Q, 32'h1);

    // Zero seed replaced, ZERO_ERR for exactly one cycle.
    load_seed(32'h0);
    chk("zero_q", Q, 32'h1);
    chk("zero_err1", ZERO_ERR, 1'b1);
    tick();
    chk("zero_err2", ZERO_ERR, 1'b0);

    // Burst of 3 with two stalled cycles.
    load_seed(32'h1);
    Q_READY = 1'b0;
    BURST_START = 1'b1; BURST_LEN = 16'd3;
    tick();
    BURST_START = 1'b0;
    chk("b_vld", Q_VALID, 1'b1);
    chk("b_busy", BUSY, 1'b1);
    chk("b_stall1", Q, 32'h1);
    tick();
    chk("b_stall2", Q, 32'h1);
    chk("b_stall_vld", Q_VALID, 1'b1);
    Q_READY = 1'b1;
    done_cnt = 0;
    chk("b_w1", Q, 32'h1);
    tick(); if (DONE) done_cnt++;
    chk("b_w2", Q, 32'h3); chk("b_w2_vld", Q_VALID, 1'b1);
    tick(); if (DONE) done_cnt++;
    chk("b_w3", Q, 32'h6); chk("b_w3_vld", Q_VALID, 1'b1);
    tick();
    chk("b_done", DONE, 1'b1);
    chk("b_end_busy", BUSY, 1'b0);
    chk("b_end_vld", Q_VALID, 1'b0);
    chk("b_end_q", Q, 32'hD);
    if (DONE) done_cnt++;
    tick(); if (DONE) done_cnt++;
    chk("b_done_cnt", done_cnt, 1);

    // RUN falls while a word is stalled.
    load_seed(32'h1);
    Q_READY = 1'b0; RUN = 1'b1;
    tick();
    chk("r_vld", Q_VALID, 1'b1);
    RUN = 1'b0;
    tick();
    chk("r_hold_vld", Q_VALID, 1'b1);
    chk("r_hold_q", Q, 32'h1);
    tick();
    chk("r_hold2_vld", Q_VALID, 1'b1);
    Q_READY = 1'b1;
    tick();
    chk("r_end_vld", Q_VALID, 1'b0);
    chk("r_end_busy", BUSY, 1'b0);
    chk("r_end_q", Q, 32'h3);

    // Zero-length burst: DONE only.
    BURST_START = 1'b1; BURST_LEN = 16'd0;
    tick();
    BURST_START = 1'b0;
    chk("z_done", DONE, 1'b1);
    chk("z_vld", Q_VALID, 1'b0);
    chk("z_busy", BUSY, 1'b0);
    tick();
    chk("z_done2", DONE, 1'b0);
    chk("z_vld2", Q_VALID, 1'b0);

    // INIT aborts a burst after one word.
    load_seed(32'h1);
    BURST_START = 1'b1; BURST_LEN = 16'd5;
    tick();
    BURST_START = 1'b0;
    chk("a_w1", Q, 32'h1);
    tick();
    chk("a_w2", Q, 32'h3);
    load_seed(32'h1234_5678);
    chk("a_q", Q, 32'h1234_5678);
    chk("a_vld", Q_VALID, 1'b0);
    chk("a_busy", BUSY, 1'b0);
    chk("a_done", DONE, 1'b0);
    tick();
    chk("a_done2", DONE, 1'b0);

    // Asynchronous reset mid-run.
    RUN = 1'b1;
    tick(); tick();
    chk("m_vld", Q_VALID, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("m_rst_q", Q, 32'h1);
    chk("m_rst_vld", Q_VALID, 1'b0);
    chk("m_rst_busy", BUSY, 1'b0);
    RUN = 1'b0;
    #3 RST_N = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
